ram_fifo_ctrl: RTL and testbench

Dual-issue FIFO controller that sits directly upstream of the two-write/two-read flip-flop `ram` and turns it into a circular FIFO. Each cycle it accepts 0–2 pushes and serves 0–2 pops. It owns the write/read pointers and drives all RAM enables, addresses and write data. It returns RAM read data to the consumer in FIFO order, with occupancy and error status.

---
 rtl/ram_fifo_ctrl_if.sv | 46 ++++
 rtl/ram_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of the FIFO controller's consumer-side and RAM-side signals.
// The slave modport is the controller; the master modport is the
// environment (producer/consumer logic plus the two-port RAM).
interface ram_fifo_ctrl_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 3
);
  logic                 flush;
  logic [1:0]           push_n;
  logic [DATAWIDTH-1:0] push_data0;
  logic [DATAWIDTH-1:0] push_data1;
  logic [1:0]           pop_n;
  logic [DATAWIDTH-1:0] out_data0;
  logic [DATAWIDTH-1:0] out_data1;
  logic [ADDRWIDTH:0]   count;
  logic                 empty;
  logic                 full;
  logic                 ovf_err;
  logic                 unf_err;
  logic                 en_w1_n;
  logic                 en_w2_n;
  logic [ADDRWIDTH-1:0] addr_w1;
  logic [ADDRWIDTH-1:0] addr_w2;
  logic [DATAWIDTH-1:0] data_w1;
  logic [DATAWIDTH-1:0] data_w2;
  logic                 en_r1_n;
  logic                 en_r2_n;
  logic [ADDRWIDTH-1:0] addr_r1;
  logic [ADDRWIDTH-1:0] addr_r2;
  logic [DATAWIDTH-1:0] data_r1;
  logic [DATAWIDTH-1:0] data_r2;

  modport slave (
    input  flush, push_n, push_data0, push_data1, pop_n, data_r1, data_r2,
    output out_data0, out_data1, count, empty, full, ovf_err, unf_err,
           en_w1_n, en_w2_n, addr_w1, addr_w2, data_w1, data_w2,
           en_r1_n, en_r2_n, addr_r1, addr_r2
  );

  modport master (
    output flush, push_n, push_data0, push_data1, pop_n, data_r1, data_r2,
    input  out_data0, out_data1, count, empty, full, ovf_err, unf_err,
           en_w1_n, en_w2_n, addr_w1, addr_w2, data_w1, data_w2,
           en_r1_n, en_r2_n, addr_r1, addr_r2
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Dual-issue circular FIFO controller in front of a 2W/2R flip-flop RAM.
// Pointers carry a wrap bit so full (count == DEPTH) and empty differ.
// Admission uses only the registered count: a same-cycle pop never
// frees room for a push, and requests are all-or-nothing.
module ram_fifo_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 3
) (
  input logic            clk,
  input logic            rst_n,
  ram_fifo_ctrl_if.slave bus
);

  localparam logic [ADDRWIDTH:0] ZERO_C  = {(ADDRWIDTH+1){1'b0}};
  localparam logic [ADDRWIDTH:0] ONE_C   = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRWIDTH:0] TWO_C   = {{(ADDRWIDTH-1){1'b0}}, 2'd2};
  localparam logic [ADDRWIDTH:0] DEPTH_C = {1'b1, {ADDRWIDTH{1'b0}}};

  logic [ADDRWIDTH:0] wr_ptr_r;
  logic [ADDRWIDTH:0] rd_ptr_r;
  logic [ADDRWIDTH:0] count_r;
  logic               ovf_err_r;
  logic               unf_err_r;

  logic [ADDRWIDTH:0] free_s;
  logic [ADDRWIDTH:0] push_ext_s;
  logic [ADDRWIDTH:0] pop_ext_s;
  logic [ADDRWIDTH:0] push_acc_s;
  logic [ADDRWIDTH:0] pop_acc_s;
  logic [ADDRWIDTH:0] wr_ptr_p1_s;
  logic [ADDRWIDTH:0] rd_ptr_p1_s;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign free_s      = DEPTH_C - count_r;
  assign push_ext_s  = {{(ADDRWIDTH-1){1'b0}}, bus.push_n};
  assign pop_ext_s   = {{(ADDRWIDTH-1){1'b0}}, bus.pop_n};
  // A request of 3 is never legal, whatever the occupancy.
  assign push_ok_s   = (bus.push_n != 2'd3) && (push_ext_s <= free_s);
  assign pop_ok_s    = (bus.pop_n != 2'd3) && (pop_ext_s <= count_r);
  assign push_acc_s  = push_ok_s ? push_ext_s : ZERO_C;
  assign pop_acc_s   = pop_ok_s ? pop_ext_s : ZERO_C;
  assign wr_ptr_p1_s = wr_ptr_r + ONE_C;
  assign rd_ptr_p1_s = rd_ptr_r + ONE_C;

  // Write-port drive: same-cycle from the request and registered write pointer.
  always_comb begin
    bus.en_w1_n = 1'b1;
    bus.en_w2_n = 1'b1;
    bus.addr_w1 = {ADDRWIDTH{1'b0}};
    bus.addr_w2 = {ADDRWIDTH{1'b0}};
    bus.data_w1 = {DATAWIDTH{1'b0}};
    bus.data_w2 = {DATAWIDTH{1'b0}};
    if (rst_n && !bus.flush && push_ok_s && (bus.push_n != 2'd0)) begin
      bus.en_w1_n = 1'b0;
      bus.addr_w1 = wr_ptr_r[ADDRWIDTH-1:0];
      bus.data_w1 = bus.push_data0;
      // Port 2 always targets the slot after port 1, so they never collide.
      if (bus.push_n == 2'd2) begin
        bus.en_w2_n = 1'b0;
        bus.addr_w2 = wr_ptr_p1_s[ADDRWIDTH-1:0];
        bus.data_w2 = bus.push_data1;
      end else begin
        bus.en_w2_n = 1'b1;
      end
    end else begin
      bus.en_w1_n = 1'b1;
      bus.en_w2_n = 1'b1;
    end
  end

  // Read-port drive: the two oldest slots, enabled by registered occupancy.
  always_comb begin
    bus.en_r1_n = 1'b1;
    bus.en_r2_n = 1'b1;
    bus.addr_r1 = {ADDRWIDTH{1'b0}};
    bus.addr_r2 = {ADDRWIDTH{1'b0}};
    if (rst_n) begin
      bus.addr_r1 = rd_ptr_r[ADDRWIDTH-1:0];
      bus.addr_r2 = rd_ptr_p1_s[ADDRWIDTH-1:0];
      bus.en_r1_n = !(count_r >= ONE_C);
      bus.en_r2_n = !(count_r >= TWO_C);
    end else begin
      bus.en_r1_n = 1'b1;
      bus.en_r2_n = 1'b1;
    end
  end

  assign bus.out_data0 = bus.data_r1;
  assign bus.out_data1 = bus.data_r2;
  assign bus.count     = count_r;
  assign bus.empty     = (count_r == ZERO_C);
  assign bus.full      = (count_r == DEPTH_C);
  assign bus.ovf_err   = ovf_err_r;
  assign bus.unf_err   = unf_err_r;

  // Pointer, occupancy and error-pulse state; flush clears it synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= ZERO_C;
      rd_ptr_r  <= ZERO_C;
      count_r   <= ZERO_C;
      ovf_err_r <= 1'b0;
      unf_err_r <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_r  <= ZERO_C;
      rd_ptr_r  <= ZERO_C;
      count_r   <= ZERO_C;
      ovf_err_r <= 1'b0;
      unf_err_r <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_ptr_r + push_acc_s;
      rd_ptr_r  <= rd_ptr_r + pop_acc_s;
      count_r   <= count_r + push_acc_s - pop_acc_s;
      ovf_err_r <= !push_ok_s;
      unf_err_r <= !pop_ok_s;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural RAM plus a queue-based FIFO
// reference; directed test-plan steps followed by random traffic.
module tb_ram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATAWIDTH(8), .ADDRWIDTH(3)) bus ();

  ram_fifo_ctrl #(.DATAWIDTH(8), .ADDRWIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural two-write / two-read RAM.
  logic [7:0] ram [0:7];
  assign bus.data_r1 = ram[bus.addr_r1];
  assign bus.data_r2 = ram[bus.addr_r2];
  always @(posedge clk) begin
    if (!bus.en_w1_n) ram[bus.addr_w1] <= bus.data_w1;
    if (!bus.en_w2_n) ram[bus.addr_w2] <= bus.data_w2;
  end

  // Reference model state.
  logic [7:0] q[$];
  int wr_idx = 0;
  int rd_idx = 0;
  bit exp_ovf = 1'b0;
  bit exp_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wr_idx = 0;
    rd_idx = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic check_state(input string ph);
    int sz;
    sz = q.size();
    chk({ph, " count"}, 32'(bus.count), 32'(sz));
    chk({ph, " empty"}, 32'(bus.empty), 32'(sz == 0));
    chk({ph, " full"}, 32'(bus.full), 32'(sz == 8));
    chk({ph, " ovf_err"}, 32'(bus.ovf_err), 32'(exp_ovf));
    chk({ph, " unf_err"}, 32'(bus.unf_err), 32'(exp_unf));
    chk({ph, " en_r1_n"}, 32'(bus.en_r1_n), 32'(sz < 1));
    chk({ph, " en_r2_n"}, 32'(bus.en_r2_n), 32'(sz < 2));
    chk({ph, " addr_r1"}, 32'(bus.addr_r1), 32'(rd_idx % 8));
    chk({ph, " addr_r2"}, 32'(bus.addr_r2), 32'((rd_idx + 1) % 8));
    if (sz >= 1) chk({ph, " out_data0"}, 32'(bus.out_data0), 32'(q[0]));
    if (sz >= 2) chk({ph, " out_data1"}, 32'(bus.out_data1), 32'(q[1]));
  endtask

  // One clock of traffic: check the write side before the edge, then the
  // registered state after it.
  task automatic step(input string ph, input logic [1:0] pn, input logic [7:0] d0,
                      input logic [7:0] d1, input logic [1:0] pp, input logic fl);
    bit push_ok;
    bit pop_ok;
    bit w1;
    bit w2;
    int sz;
    bus.push_n = pn;
    bus.push_data0 = d0;
    bus.push_data1 = d1;
    bus.pop_n = pp;
    bus.flush = fl;
    #2;
    sz = q.size();
    push_ok = (pn != 2'd3) && (int'(pn) <= 8 - sz);
    pop_ok = (pp != 2'd3) && (int'(pp) <= sz);
    w1 = !fl && push_ok && (pn >= 2'd1);
    w2 = !fl && push_ok && (pn == 2'd2);
    chk({ph, " en_w1_n"}, 32'(bus.en_w1_n), 32'(!w1));
    chk({ph, " en_w2_n"}, 32'(bus.en_w2_n), 32'(!w2));
    if (w1) begin
      chk({ph, " addr_w1"}, 32'(bus.addr_w1), 32'(wr_idx % 8));
      chk({ph, " data_w1"}, 32'(bus.data_w1), 32'(d0));
    end
    if (w2) begin
      chk({ph, " addr_w2"}, 32'(bus.addr_w2), 32'((wr_idx + 1) % 8));
      chk({ph, " data_w2"}, 32'(bus.data_w2), 32'(d1));
    end
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < int'(pp); i++) void'(q.pop_front());
        rd_idx = (rd_idx + int'(pp)) % 8;
      end
      if (push_ok) begin
        if (pn >= 2'd1) q.push_back(d0);
        if (pn == 2'd2) q.push_back(d1);
        wr_idx = (wr_idx + int'(pn)) % 8;
      end
      exp_ovf = !push_ok;
      exp_unf = !pop_ok;
    end
    #1;
    check_state(ph);
  endtask

  task automatic check_reset(input string ph);
    chk({ph, " count"}, 32'(bus.count), 32'd0);
    chk({ph, " empty"}, 32'(bus.empty), 32'd1);
    chk({ph, " full"}, 32'(bus.full), 32'd0);
    chk({ph, " ovf_err"}, 32'(bus.ovf_err), 32'd0);
    chk({ph, " unf_err"}, 32'(bus.unf_err), 32'd0);
    chk({ph, " enables"}, 32'({bus.en_w1_n, bus.en_w2_n, bus.en_r1_n, bus.en_r2_n}), 32'hF);
    chk({ph, " addrs"}, 32'({bus.addr_w1, bus.addr_w2, bus.addr_r1, bus.addr_r2}), 32'd0);
    chk({ph, " data_w"}, 32'({bus.data_w1, bus.data_w2}), 32'd0);
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.push_n = 2'd2;
    bus.push_data0 = 8'h00;
    bus.push_data1 = 8'h00;
    bus.pop_n = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    bus.push_n = 2'd0;
    rst_n = 1'b1;
    model_clear();

    // Dual push from empty, then fill to full and overflow.
    step("dual_push", 2'd2, 8'hA1, 8'hA2, 2'd0, 1'b0);
    chk("dual_push out0_abs", 32'(bus.out_data0), 32'hA1);
    step("fill1", 2'd2, 8'hB1, 8'hB2, 2'd0, 1'b0);
    step("fill2", 2'd2, 8'hC1, 8'hC2, 2'd0, 1'b0);
    step("fill3", 2'd2, 8'hD1, 8'hD2, 2'd0, 1'b0);
    chk("full_abs", 32'(bus.full), 32'd1);
    chk("count8_abs", 32'(bus.count), 32'd8);
    step("ovf_push", 2'd1, 8'hEE, 8'hEF, 2'd0, 1'b0);
    chk("ovf_abs", 32'(bus.ovf_err), 32'd1);
    step("ovf_clear", 2'd0, 8'h00, 8'h00, 2'd0, 1'b0);

    // Wrap: drain to one entry at index 7, then push across the rollover.
    step("wrap_pop2a", 2'd0, 8'h00, 8'h00, 2'd2, 1'b0);
    step("wrap_pop2b", 2'd0, 8'h00, 8'h00, 2'd2, 1'b0);
    step("wrap_pop2c", 2'd0, 8'h00, 8'h00, 2'd2, 1'b0);
    step("wrap_pop1", 2'd0, 8'h00, 8'h00, 2'd1, 1'b0);
    chk("wrap_rd7_abs", 32'(bus.addr_r1), 32'd7);
    step("wrap_push_a", 2'd2, 8'h11, 8'h12, 2'd0, 1'b0);
    step("wrap_push_b", 2'd2, 8'h13, 8'h14, 2'd0, 1'b0);
    chk("wrap_r2_abs", 32'(bus.out_data1), 32'h11);

    // Simultaneous push and pop.
    step("sim_fill6", 2'd1, 8'h15, 8'h00, 2'd0, 1'b0);
    step("sim_p2p2", 2'd2, 8'h21, 8'h22, 2'd2, 1'b0);
    step("sim_fill7", 2'd1, 8'h23, 8'h00, 2'd0, 1'b0);
    step("sim_p2p1", 2'd2, 8'h31, 8'h32, 2'd1, 1'b0);

    // Underflow, illegal push and flush.
    step("drain_a", 2'd0, 8'h00, 8'h00, 2'd2, 1'b0);
    step("drain_b", 2'd0, 8'h00, 8'h00, 2'd2, 1'b0);
    step("drain_c", 2'd0, 8'h00, 8'h00, 2'd1, 1'b0);
    step("unf_pop2", 2'd0, 8'h00, 8'h00, 2'd2, 1'b0);
    step("illegal_push3", 2'd3, 8'h41, 8'h42, 2'd0, 1'b0);
    step("illegal_pop3", 2'd1, 8'h43, 8'h00, 2'd3, 1'b0);
    step("flush_push2", 2'd2, 8'h51, 8'h52, 2'd0, 1'b1);

    // Reset in the middle of traffic, with a push request still driven.
    step("pre_rst_a", 2'd2, 8'h61, 8'h62, 2'd0, 1'b0);
    step("pre_rst_b", 2'd2, 8'h63, 8'h64, 2'd1, 1'b0);
    bus.push_n = 2'd2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    model_clear();
    @(posedge clk);
    #1;
    bus.push_n = 2'd0;
    rst_n = 1'b1;

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 8'($urandom),
           8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 31) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
